// File: rtl/access_cache_model.sv
// Direct-mapped cache timing/statistics model: counts hits, misses and dirty
// write-backs and stalls the requester through ready_o during refills.
// The optional write-back policy is enabled by defining ACCESS_CACHE_WB_EN.
//
// state  | meaning
// IDLE   | ready for a request; hits complete here
// WB     | dirty victim being written back (ACCESS_CACHE_WB_EN only)
// REFILL | block fetch; the line is installed on the last cycle
module access_cache_model #(
    parameter int ADDR_W       = 32,
    parameter int OFFSET_BITS  = 4,
    parameter int INDEX_BITS   = 4,
    parameter int MISS_PENALTY = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              hit_o,
    output logic              miss_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic [CNT_W-1:0]  wb_cnt_o
);

    localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    localparam logic [7:0] PEN_LOAD = 8'(MISS_PENALTY - 1);

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

    state_t                  state_q, state_nxt;
    logic [7:0]              timer_q, timer_nxt;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [INDEX_BITS-1:0]   req_idx, lat_idx;
    logic [TAG_W-1:0]        req_tag, lat_tag;
    logic                    hit, miss, install;

    assign req_idx = addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag = addr_i[ADDR_W-1:OFFSET_BITS+INDEX_BITS];
    assign ready_o = (state_q == IDLE);

`ifdef ACCESS_CACHE_WB_EN
    logic [LINES-1:0] dirty_q;
    logic             lat_we;
    logic             wb;
    logic             unused_offset;
    assign unused_offset = ^addr_i[OFFSET_BITS-1:0];
`else
    logic             unused_in;
    assign unused_in = ^{we_i, addr_i[OFFSET_BITS-1:0]};
    assign wb_cnt_o  = '0;
`endif

    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        hit       = 1'b0;
        miss      = 1'b0;
        install   = 1'b0;
`ifdef ACCESS_CACHE_WB_EN
        wb        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
                        hit = 1'b1;
                    end else begin
                        miss      = 1'b1;
                        timer_nxt = PEN_LOAD;
`ifdef ACCESS_CACHE_WB_EN
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            wb        = 1'b1;
                            state_nxt = WB;
                        end else begin
                            state_nxt = REFILL;
                        end
`else
                        state_nxt = REFILL;
`endif
                    end
                end
            end
`ifdef ACCESS_CACHE_WB_EN
            WB: begin
                if (timer_q == 8'd0) begin
                    state_nxt = REFILL;
                    timer_nxt = PEN_LOAD;
                end else begin
                    timer_nxt = timer_q - 8'd1;
                end
            end
`endif
            REFILL: begin
                if (timer_q == 8'd0) begin
                    install   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_q - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            timer_q    <= 8'd0;
            valid_q    <= '0;
            hit_o      <= 1'b0;
            miss_o     <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            lat_idx    <= '0;
            lat_tag    <= '0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
            hit_o   <= hit;
            miss_o  <= miss;
            if (hit && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + CNT_W'(1);
            if (miss && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + CNT_W'(1);
            if (miss) begin
                lat_idx <= req_idx;
                lat_tag <= req_tag;
            end
            if (install)
                valid_q[lat_idx] <= 1'b1;
        end
    end

`ifdef ACCESS_CACHE_WB_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dirty_q  <= '0;
            lat_we   <= 1'b0;
            wb_cnt_o <= '0;
        end else begin
            if (miss)
                lat_we <= we_i;
            if (wb && (wb_cnt_o != '1))
                wb_cnt_o <= wb_cnt_o + CNT_W'(1);
            if (hit && we_i)
                dirty_q[req_idx] <= 1'b1;
            // write-allocate: the refilled line takes the dirtiness of the miss
            if (install)
                dirty_q[lat_idx] <= lat_we;
        end
    end
`endif

    // tags need no reset; a line is only trusted once its valid bit is set
    always_ff @(posedge clk_i) begin
        if (!rst_i && install)
            tag_q[lat_idx] <= lat_tag;
    end

endmodule

// File: tb/tb_access_cache_model.sv
// Directed bench for access_cache_model: vector table for the access stream
// plus hand-written streaming, reset-mid-refill and saturation sequences.
module tb_access_cache_model;

    localparam int P = 4;
`ifdef ACCESS_CACHE_WB_EN
    localparam int WB_ON = 1;
`else
    localparam int WB_ON = 0;
`endif

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [31:0] addr;
    logic        ready, hit, miss;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;

    logic        s_req, s_we;
    logic [31:0] s_addr;
    logic        s_ready, s_hit, s_miss;
    logic [1:0]  s_hit_cnt, s_miss_cnt, s_wb_cnt;

    int total = 0;
    int bad   = 0;

    access_cache_model #(.MISS_PENALTY(P)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .ready_o(ready), .hit_o(hit), .miss_o(miss),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt)
    );

    access_cache_model #(.MISS_PENALTY(P), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .req_i(s_req), .we_i(s_we), .addr_i(s_addr),
        .ready_o(s_ready), .hit_o(s_hit), .miss_o(s_miss),
        .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt), .wb_cnt_o(s_wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic        eh;
        logic        em;
        int          stall;
        int          hits;
        int          misses;
        int          wbs;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        if (!ready) check({name, "_ready_timeout"}, 32'(ready), 32'd1);
    endtask

    task automatic do_access(input string name, input logic w, input logic [31:0] a,
                             input logic eh, input logic em, input int stall);
        int n;
        wait_ready(name);
        req = 1'b1; we = w; addr = a;
        step();
        req = 1'b0; we = 1'b0;
        check({name, "_hit"}, 32'(hit), 32'(eh));
        check({name, "_miss"}, 32'(miss), 32'(em));
        n = 0;
        while (!ready && n < 50) begin
            step();
            n++;
        end
        check({name, "_stall"}, 32'(n), 32'(stall));
    endtask

    initial begin
        req = 0; we = 0; addr = 0; s_req = 0; s_we = 0; s_addr = 0;
        rst = 1'b1;
        step();
        step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        check("rst_wb_cnt", wb_cnt, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(ready), 32'd1);

        //         we    addr        hit   miss  stall            h  m  wb
        vecs[0] = '{1'b0, 32'h000, 1'b0, 1'b1, P,              0, 1, 0};
        vecs[1] = '{1'b0, 32'h004, 1'b1, 1'b0, 0,              1, 1, 0};
        vecs[2] = '{1'b0, 32'h100, 1'b0, 1'b1, P,              1, 2, 0};
        vecs[3] = '{1'b0, 32'h000, 1'b0, 1'b1, P,              1, 3, 0};
        vecs[4] = '{1'b1, 32'h000, 1'b1, 1'b0, 0,              2, 3, 0};
        vecs[5] = '{1'b0, 32'h100, 1'b0, 1'b1, P + P * WB_ON,  2, 4, WB_ON};
        vecs[6] = '{1'b1, 32'h200, 1'b0, 1'b1, P,              2, 5, WB_ON};
        vecs[7] = '{1'b0, 32'h000, 1'b0, 1'b1, P + P * WB_ON,  2, 6, 2 * WB_ON};
        vecs[8] = '{1'b1, 32'h010, 1'b0, 1'b1, P,              2, 7, 2 * WB_ON};
        vecs[9] = '{1'b0, 32'h014, 1'b1, 1'b0, 0,              3, 7, 2 * WB_ON};

        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            do_access(nm, vecs[i].w, vecs[i].a, vecs[i].eh, vecs[i].em, vecs[i].stall);
            check({nm, "_hit_cnt"}, hit_cnt, 32'(vecs[i].hits));
            check({nm, "_miss_cnt"}, miss_cnt, 32'(vecs[i].misses));
            check({nm, "_wb_cnt"}, wb_cnt, 32'(vecs[i].wbs));
        end

        // streaming hits on the resident 0x000 line with req held high
        wait_ready("stream");
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(i * 4);
            step();
            check($sformatf("stream%0d_hit", i), 32'(hit), 32'd1);
            check($sformatf("stream%0d_ready", i), 32'(ready), 32'd1);
            check($sformatf("stream%0d_hit_cnt", i), hit_cnt, 32'(4 + i));
        end
        req = 1'b0;
        step();
        check("stream_end_hit", 32'(hit), 32'd0);
        check("stream_hit_cnt", hit_cnt, 32'd7);

        // reset two cycles into the refill of 0x040
        req = 1'b1; we = 1'b0; addr = 32'h040;
        step();
        req = 1'b0;
        check("mid_miss", 32'(miss), 32'd1);
        check("mid_stalled", 32'(ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_hit_cnt", hit_cnt, 32'd0);
        check("mid_rst_miss_cnt", miss_cnt, 32'd0);
        check("mid_rst_wb_cnt", wb_cnt, 32'd0);
        check("mid_rst_miss", 32'(miss), 32'd0);
        do_access("after_rst_040", 1'b0, 32'h040, 1'b0, 1'b1, P);
        check("after_rst_miss_cnt", miss_cnt, 32'd1);
        do_access("after_rst_000", 1'b0, 32'h000, 1'b0, 1'b1, P);
        do_access("after_rst_044", 1'b0, 32'h044, 1'b1, 1'b0, 0);
        check("after_rst_hit_cnt", hit_cnt, 32'd1);

        // saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            int n;
            n = 0;
            while (!s_ready && n < 100) begin
                step();
                n++;
            end
            s_req = 1'b1; s_addr = 32'(i * 16);
            step();
            s_req = 1'b0;
            check($sformatf("sat%0d_miss", i), 32'(s_miss), 32'd1);
            check($sformatf("sat%0d_miss_cnt", i), {30'b0, s_miss_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("sat_hit_cnt", {30'b0, s_hit_cnt}, 32'd0);
        check("sat_wb_cnt", {30'b0, s_wb_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/access_cache_model.md
# access_cache_model

Cycle-level direct-mapped cache model for the single-cycle CPU's instruction or data memory access stream. It consumes the same per-cycle access indication the bench traces today: the fetch address, or the data address with read/write. It counts hits, misses and dirty write-backs in hardware and emulates miss penalty through a ready/stall handshake. Two instances are planned, one on the instruction-fetch path and one on the data-memory path, so hit rate can be read directly instead of post-processed from the ICACHE/DCACHE trace files.

## Interface
Parameters:
- ADDR_W, 32: access address width.
- OFFSET_BITS, 4: byte-offset bits; block size is 2^OFFSET_BITS bytes.
- INDEX_BITS, 4: index bits; the cache has 2^INDEX_BITS lines.
- MISS_PENALTY, 4: stall cycles per refill or write-back; legal range 1..255.
- CNT_W, 32: statistics counter width.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  access request valid.
- we_i  in  1  1 = write (store), 0 = read or fetch; sampled with req_i.
- addr_i  in  ADDR_W  byte address of the access.
- ready_o  out  1  model accepts a request this cycle.
- hit_o  out  1  one-cycle pulse, the cycle after a hit is accepted.
- miss_o  out  1  one-cycle pulse, the cycle after a miss is accepted.
- hit_cnt_o  out  CNT_W  accepted hits.
- miss_cnt_o  out  CNT_W  accepted misses.
- wb_cnt_o  out  CNT_W  dirty evictions.

## Operation
- Address split: tag = addr_i[ADDR_W-1:OFFSET_BITS+INDEX_BITS]; index = addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]; offset is ignored.
- Per line storage: valid bit, dirty bit, tag.
- FSM states:
  - IDLE: ready_o=1.
  - WB: write-back of dirty victim.
  - REFILL: block fetch.
- Acceptance: a request is accepted on the rising edge where req_i and ready_o are both 1. While ready_o=0, req_i is ignored and the requester holds its request.
- Hit (valid and tags equal):
  - hit_cnt increments; hit_o pulses.
  - On a write, dirty is set.
  - FSM stays in IDLE.
- Miss:
  - miss_cnt increments; miss_o pulses.
  - Index, tag and we are latched.
  - If the victim line is valid and dirty: wb_cnt increments, FSM goes to WB, then to REFILL.
  - Otherwise FSM goes directly to REFILL.
- WB and REFILL each last exactly MISS_PENALTY cycles, timed by an 8-bit down-counter.
- End of REFILL: line installed with valid=1, latched tag, dirty=latched we. FSM returns to IDLE.
- Write-allocate: a write miss refills, then the line is marked dirty.
- Counters saturate at all-ones and never wrap.
- The tag array is not readable externally.

## Timing
- Reset values: all valid and dirty bits cleared, FSM in IDLE, all counters 0, hit_o=miss_o=0.
- ready_o is combinational from state (IDLE -> 1), so it is 1 in the cycle after reset deasserts.
- Hit latency: the hit_o pulse and the updated hit_cnt_o are visible the cycle after the accepting edge.
- Back-to-back hits are accepted on consecutive edges.
- Clean miss accepted at edge N:
  - miss_o is high during cycle N+1.
  - ready_o is 0 for cycles N+1 .. N+MISS_PENALTY.
  - The next request can be accepted at edge N+MISS_PENALTY+1.
- Dirty miss: ready_o is 0 for 2*MISS_PENALTY cycles.
- Counter update is simultaneous with the hit_o/miss_o pulse.
- rst_i has priority over everything, including mid-WB or mid-REFILL. In that case the pending line is not installed and all state returns to reset values on that edge.
- Same-index requests during WB/REFILL cannot occur because ready_o=0.

## Configuration
- ACCESS_CACHE_WB_EN defined:
  - Write-back policy with dirty tracking and the WB state as described above.
- ACCESS_CACHE_WB_EN undefined:
  - No dirty bits and no WB state; every miss goes straight to REFILL.
  - Writes behave exactly as reads (allocate on miss, hit on match).
  - wb_cnt_o is tied to 0.

## Test plan
Defaults apply unless stated: OFFSET_BITS=4, INDEX_BITS=4, MISS_PENALTY=4, ACCESS_CACHE_WB_EN defined.
1. Cold miss then spatial hit.
   - Stimulus: after reset, read 0x00000000, then read 0x00000004.
   - Required: miss_o pulse, ready_o low for 4 cycles, miss_cnt=1; then hit_o the next cycle, hit_cnt=1.
2. Conflict misses.
   - Stimulus: read 0x000, read 0x100, read 0x000 (all index 0, tags differ).
   - Required: three misses, miss_cnt=3, hit_cnt=0, wb_cnt=0.
3. Dirty eviction.
   - Stimulus: write 0x000, then read 0x100.
   - Required: second access stalls ready_o for 8 cycles, wb_cnt=1, miss_cnt=2.
   - Repeat with the macro undefined: required stall is 4 cycles and wb_cnt stays 0.
4. Streaming hits.
   - Stimulus: after the 0x000 line is resident, hold req_i high with addresses 0x000, 0x004, 0x008, 0x00C.
   - Required: accepted on 4 consecutive edges, 4 consecutive hit_o cycles, hit_cnt=4.
5. Reset mid-refill.
   - Stimulus: assert rst_i 2 cycles into the refill for 0x040.
   - Required: all counters 0 and ready_o=1 next cycle; a following read of 0x040 misses.
6. Saturation.
   - Stimulus: with CNT_W=2, 5 cold misses to distinct indices.
   - Required: miss_cnt_o stays at 3.
